// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: operation encodings reused by the ALU, the arbiter and their benches,
// plus the arbiter state encoding.
package alu_arbiter_pkg;

  localparam int unsigned AluOpW = 4;

  localparam logic [AluOpW-1:0] OP_ADD  = 4'b0000;
  localparam logic [AluOpW-1:0] OP_SUB  = 4'b0001;
  localparam logic [AluOpW-1:0] OP_AND  = 4'b0010;
  localparam logic [AluOpW-1:0] OP_OR   = 4'b0011;
  localparam logic [AluOpW-1:0] OP_XOR  = 4'b0100;
  localparam logic [AluOpW-1:0] OP_SLL  = 4'b0101;
  localparam logic [AluOpW-1:0] OP_SRL  = 4'b0110;
  localparam logic [AluOpW-1:0] OP_SLT  = 4'b0111;
  localparam logic [AluOpW-1:0] OP_SLTU = 4'b1000;

  // Arbiter states
  localparam logic [0:0] StIdle = 1'b0;  // no response held
  localparam logic [0:0] StHold = 1'b1;  // one response held for the owner

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant logic, purely combinational.
// Ports:
//   valid_i       request valid per port
//   last_grant_i  port granted most recently
//   enable_i      grant may be issued this cycle
//   grant_valid_o a port is granted
//   grant_idx_o   index of the granted port
module alu_arbiter_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       enable_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_valid_o = enable_i & (|valid_i);
    // On contention the port that did not win last time goes first.
    if (valid_i == 2'b11) begin
      grant_idx_o = ~last_grant_i;
    end else begin
      grant_idx_o = valid_i[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters. The granted request drives the
// ALU in the accept cycle; its result and zero flag are registered and returned on the owner's
// response channel one cycle later. Contention is resolved round-robin.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   reqN_valid/ready            request handshake, port N
//   reqN_src_a/src_b/alu_op     request operands and operation
//   rspN_valid/ready            response handshake, port N
//   rsp_result, rsp_zero        registered response data shared by both channels
//   alu_src_a/src_b/alu_op      drive to the external ALU
//   alu_result, alu_zero        ALU outputs
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_src_a,
  input  logic [WIDTH-1:0] req0_src_b,
  input  logic [OP_W-1:0]  req0_alu_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_src_a,
  input  logic [WIDTH-1:0] req1_src_b,
  input  logic [OP_W-1:0]  req1_alu_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  logic [0:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic free;
  logic owner_ready;
  logic grant_valid;
  logic grant_idx;

  assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;
  // Free when nothing is held, or the held response is being consumed this cycle.
  assign free = (state_q == StIdle) | owner_ready;

  alu_arbiter_rr_arb2 u_rr_arb2 (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .enable_i     (free),
    .grant_valid_o(grant_valid),
    .grant_idx_o  (grant_idx)
  );

  assign req0_ready = grant_valid & ~grant_idx;
  assign req1_ready = grant_valid &  grant_idx;

  always_comb begin
    alu_src_a = '0;
    alu_src_b = '0;
    alu_op    = OP_W'(OP_ADD);
    if (grant_valid) begin
      if (grant_idx) begin
        alu_src_a = req1_src_a;
        alu_src_b = req1_src_b;
        alu_op    = req1_alu_op;
      end else begin
        alu_src_a = req0_src_a;
        alu_src_b = req0_src_b;
        alu_op    = req0_alu_op;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    zero_d       = zero_q;
    if (grant_valid) begin
      // A grant always carries a valid request, so it is an accept.
      state_d      = StHold;
      owner_d      = grant_idx;
      last_grant_d = grant_idx;
      result_d     = alu_result;
      zero_d       = alu_zero;
    end else if (state_q == StHold && owner_ready) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

  assign rsp0_valid = (state_q == StHold) & ~owner_q;
  assign rsp1_valid = (state_q == StHold) &  owner_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule
